// File: rtl/ti_c2h_pkt_fifo.sv
// ti_c2h_pkt_fifo
// Store-and-forward packet buffer between the TI node C2H event stream and the
// XDMA C2H slave port. Only packets that have been completely written (closed
// by tlast) become visible to the read side. A packet that runs into a full
// buffer is discarded whole and counted, so the DMA never sees a truncated
// event block.
//
// Ports (all in the CLKReg domain):
//   CLKReg, RSTReg          clock, synchronous active-high reset
//   s_axis_t{data,keep,last,valid} / s_axis_tready
//                           input stream; tready is 1 whenever not in reset
//   m_axis_t{data,keep,last,valid} / m_axis_tready
//                           output stream to the DMA
//   pkt_level               committed packets whose last word is not yet sent
//   drop_count              packets dropped for overflow, saturating
//   overflow                one-cycle pulse when a drop begins
module ti_c2h_pkt_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  CLKReg,
    input  logic                  RSTReg,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   pkt_level,
    output logic [15:0]           drop_count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int W     = 73;   // {last, keep[7:0], data[63:0]}

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;
    typedef enum logic [1:0] {ST_SYNC, ST_PASS, ST_DROP} wr_state_e;

    localparam lvl_t LVL_ONE = lvl_t'(1);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_e    state_q;
    ptr_t         wr_ptr_q;
    ptr_t         wr_commit_q;
    ptr_t         rd_ptr_q;
    ptr_t         wr_ptr_inc;
    logic [15:0]  drop_count_q;
    logic         overflow_q;
    logic         s_hs;
    logic         full;
    logic         do_write;
    logic         do_commit;

    assign s_axis_tready = ~RSTReg;
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign wr_ptr_inc    = wr_ptr_q + PTR_ONE;
    // Uses the registered read pointer, so a slot freed by a fetch in this
    // same cycle only becomes usable one cycle later.
    assign full          = (wr_ptr_inc == rd_ptr_q);
    assign do_write      = (state_q == ST_PASS) && s_hs && !full;
    assign do_commit     = do_write && s_axis_tlast;

    always_ff @(posedge CLKReg) begin
        if (RSTReg) begin
            state_q      <= ST_SYNC;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            unique case (state_q)
                // Discard the tail of whatever packet was cut by reset.
                ST_SYNC: begin
                    if (s_hs && s_axis_tlast) state_q <= ST_PASS;
                end
                ST_PASS: begin
                    if (s_hs) begin
                        if (!full) begin
                            wr_ptr_q <= wr_ptr_inc;
                            if (s_axis_tlast) wr_commit_q <= wr_ptr_inc;
                        end else begin
                            // Rewind over the partial packet and count it once.
                            wr_ptr_q   <= wr_commit_q;
                            overflow_q <= 1'b1;
                            if (drop_count_q != 16'hFFFF)
                                drop_count_q <= drop_count_q + 16'd1;
                            if (!s_axis_tlast) state_q <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_hs && s_axis_tlast) state_q <= ST_PASS;
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge CLKReg) begin
        if (do_write) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    // ------------------------------------------------------------------
    // Read side: RAM read register feeding a 2-entry output stage.
    // The word just read out of the RAM is presented directly when the stage
    // is empty; if it is not accepted it moves into stg0 unchanged, so the
    // presented data stays stable across the hand-over.
    // ------------------------------------------------------------------
    logic         rd_vld_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic [W-1:0] stg0_q;
    logic [W-1:0] stg1_q;
    logic [W-1:0] stg0_d;
    logic [W-1:0] stg1_d;
    logic [W-1:0] cand0;
    logic [W-1:0] cand1;
    logic         readable;
    logic         head_vld;
    logic         pop;
    logic         fetch;

    assign readable = (rd_ptr_q != wr_commit_q);
    // Oldest item first: staged entries, then the RAM read register.
    assign cand0    = (cnt_q != 2'd0) ? stg0_q : rd_data_q;
    assign cand1    = (cnt_q == 2'd2) ? stg1_q : rd_data_q;
    assign head_vld = (cnt_q != 2'd0) || rd_vld_q;
    assign pop      = head_vld && m_axis_tready;

    always_comb begin
        cnt_d  = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        stg0_d = pop ? cand1 : cand0;
        stg1_d = cand1;
        // A fetch now lands next cycle; only issue it if that word will have
        // a stage entry to fall into.
        fetch  = readable && (cnt_d != 2'd2);
    end

    always_ff @(posedge CLKReg) begin
        if (RSTReg) begin
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
            cnt_q    <= '0;
            stg0_q   <= '0;
            stg1_q   <= '0;
        end else begin
            rd_vld_q <= fetch;
            cnt_q    <= cnt_d;
            stg0_q   <= stg0_d;
            stg1_q   <= stg1_d;
            if (fetch) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge CLKReg) begin
        if (fetch) rd_data_q <= mem[rd_ptr_q];
    end

    // Outputs are forced to zero while nothing valid is presented; this also
    // hides the unreset RAM read register after reset.
    assign m_axis_tvalid = head_vld;
    assign m_axis_tdata  = head_vld ? cand0[63:0]  : 64'd0;
    assign m_axis_tkeep  = head_vld ? cand0[71:64] : 8'd0;
    assign m_axis_tlast  = head_vld ? cand0[72]    : 1'b0;

    // ------------------------------------------------------------------
    // Packet level
    // ------------------------------------------------------------------
    lvl_t pkt_level_q;
    lvl_t pkt_level_d;
    logic out_last;

    assign out_last = pop && cand0[72];

    always_comb begin
        pkt_level_d = pkt_level_q;
        unique case ({do_commit, out_last})
            2'b10:   pkt_level_d = pkt_level_q + LVL_ONE;
            2'b01:   pkt_level_d = pkt_level_q - LVL_ONE;
            default: pkt_level_d = pkt_level_q;
        endcase
    end

    always_ff @(posedge CLKReg) begin
        if (RSTReg) pkt_level_q <= '0;
        else        pkt_level_q <= pkt_level_d;
    end

    assign pkt_level  = pkt_level_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ti_c2h_pkt_fifo.sv
// Bench for ti_c2h_pkt_fifo with a 16-word buffer (15 usable words).
// Reference model: a queue of the words expected on m_axis, filled by the
// stimulus according to which packets must be forwarded, plus expected
// drop counts derived from the buffer capacity.
module tb_ti_c2h_pkt_fifo;
    localparam int DL2 = 4;
    localparam int CAP = (1 << DL2) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [63:0]    s_axis_tdata = '0;
    logic [7:0]     s_axis_tkeep = '0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [63:0]    m_axis_tdata;
    logic [7:0]     m_axis_tkeep;
    logic           m_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic [DL2:0]   pkt_level;
    logic [15:0]    drop_count;
    logic           overflow;

    always #5 clk = ~clk;

    ti_c2h_pkt_fifo #(.DEPTH_LOG2(DL2)) dut (
        .CLKReg        (clk),
        .RSTReg        (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_level     (pkt_level),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [72:0] exp_q[$];
    int          sent_words = 0;
    int          out_words  = 0;
    int          out_pkts   = 0;
    int          ovf_pulses = 0;
    int          ready_mode = 1;   // 0 low, 1 high, 2 random
    logic        prev_stall = 1'b0;
    logic [72:0] prev_word  = '0;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // DMA ready generator
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(7) != 0);
        endcase
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        logic [72:0] w;
        logic [72:0] e;
        w = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (overflow) ovf_pulses++;
            if (prev_stall) begin
                check_eq("stall_valid", 80'(m_axis_tvalid), 80'(1));
                check_eq("stall_data", 80'(w), 80'(prev_word));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_words++;
                check_eq("word_expected", 80'(exp_q.size() != 0), 80'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_word", 80'(w), 80'(e));
                end
                if (m_axis_tlast) begin
                    out_pkts++;
                    $display("[%0t] packet %0d delivered, last data 0x%016h, words out %0d",
                             $time, out_pkts, m_axis_tdata, out_words);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = w;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [72:0] w);
        s_axis_tdata  = w[63:0];
        s_axis_tkeep  = w[71:64];
        s_axis_tlast  = w[72];
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_word(input logic [72:0] w, input bit fwd);
        if (fwd) exp_q.push_back(w);
        drive_word(w);
        if (fwd) sent_words++;
    endtask

    task automatic send_pkt(input int len, input bit fwd, input bit gaps);
        for (int i = 0; i < len; i++) begin
            logic [72:0] w;
            if (gaps && $urandom_range(7) == 0) wait_cycles(1);
            w = {(i == len - 1), 8'($urandom), $urandom, $urandom};
            send_word(w, fwd);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            wait_cycles(1);
            t++;
        end
        check_eq(tag, 80'(exp_q.size()), 80'(0));
        wait_cycles(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_drops;
        int ovf0;
        int ow0;
        int op0;
        exp_drops = 0;

        // ---------------- Reset state ----------------
        ready_mode = 1;
        wait_cycles(3);
        check_eq("rst_s_tready", 80'(s_axis_tready), 80'(0));
        check_eq("rst_m_tvalid", 80'(m_axis_tvalid), 80'(0));
        check_eq("rst_m_word", 80'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 80'(0));
        check_eq("rst_pkt_level", 80'(pkt_level), 80'(0));
        check_eq("rst_drop_count", 80'(drop_count), 80'(0));
        check_eq("rst_overflow", 80'(overflow), 80'(0));
        rst = 1'b0;
        #1;
        check_eq("post_rst_s_tready", 80'(s_axis_tready), 80'(1));
        wait_cycles(1);

        // ---------------- T1: SYNC discard, then latency ----------------
        send_pkt(4, 1'b0, 1'b0);
        wait_cycles(3);
        check_eq("sync_drop_count", 80'(drop_count), 80'(0));
        check_eq("sync_no_output", 80'(out_words), 80'(0));
        send_word({1'b0, 8'hFF, 64'h11}, 1'b1);
        send_word({1'b0, 8'hFF, 64'h22}, 1'b1);
        send_word({1'b1, 8'hFF, 64'h33}, 1'b1);
        @(negedge clk);
        check_eq("lat_t1_valid", 80'(m_axis_tvalid), 80'(0));
        @(negedge clk);
        check_eq("lat_t2_valid", 80'(m_axis_tvalid), 80'(1));
        check_eq("lat_t2_data", 80'(m_axis_tdata), 80'(64'h11));
        wait_cycles(1);
        wait_drain("t1_drain", 50);
        check_eq("t1_pkt_level", 80'(pkt_level), 80'(0));

        // ---------------- T2: fill with DMA stalled ----------------
        ready_mode = 0;
        wait_cycles(1);
        ow0 = out_words;
        op0 = out_pkts;
        for (int p = 0; p < 3; p++) send_pkt(5, 1'b1, 1'b0);
        wait_cycles(4);
        check_eq("fill_pkt_level", 80'(pkt_level), 80'(3));
        ovf0 = ovf_pulses;
        send_pkt(5, 1'b0, 1'b0);
        exp_drops++;
        wait_cycles(3);
        check_eq("fill_ovf_pulses", 80'(ovf_pulses - ovf0), 80'(1));
        check_eq("fill_drop_count", 80'(drop_count), 80'(exp_drops));
        check_eq("fill_pkt_level_hold", 80'(pkt_level), 80'(3));
        ready_mode = 1;
        wait_drain("fill_drain", 100);
        check_eq("fill_words_out", 80'(out_words - ow0), 80'(15));
        check_eq("fill_pkts_out", 80'(out_pkts - op0), 80'(3));
        check_eq("fill_level_empty", 80'(pkt_level), 80'(0));

        // ---------------- T4: oversize packet ----------------
        ovf0 = ovf_pulses;
        send_pkt(20, 1'b0, 1'b0);
        exp_drops++;
        send_pkt(2, 1'b1, 1'b0);
        wait_drain("big_drain", 50);
        check_eq("big_drop_count", 80'(drop_count), 80'(exp_drops));
        check_eq("big_ovf_pulses", 80'(ovf_pulses - ovf0), 80'(1));

        // ---------------- T3: random traffic with backpressure ----------------
        ready_mode = 2;
        ovf0 = ovf_pulses;
        for (int p = 0; p < 1000; p++) begin
            int len;
            int tmo;
            len = $urandom_range(12, 1);
            tmo = 0;
            // Admit a packet only if it fits even if nothing has left the
            // buffer yet, so no drop is legal in this phase.
            while ((sent_words - out_words) + len > CAP && tmo < 2000) begin
                wait_cycles(1);
                tmo++;
            end
            if (tmo >= 2000) begin
                check_eq("rand_throttle", 80'(tmo), 80'(0));
                break;
            end
            send_pkt(len, 1'b1, 1'b1);
        end
        ready_mode = 1;
        wait_drain("rand_drain", 500);
        check_eq("rand_no_overflow", 80'(ovf_pulses - ovf0), 80'(0));
        check_eq("rand_drop_count", 80'(drop_count), 80'(exp_drops));
        check_eq("rand_level_empty", 80'(pkt_level), 80'(0));

        // ---------------- T5: reset mid-packet and mid-stall ----------------
        ready_mode = 0;
        wait_cycles(1);
        send_pkt(3, 1'b1, 1'b0);   // lost to the reset below
        wait_cycles(4);
        send_pkt(2, 1'b0, 1'b0);   // first two words of a 5-word packet
        s_axis_tdata  = 64'hDEAD_0003;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        sent_words = out_words;
        exp_drops  = 0;
        check_eq("mid_rst_m_tvalid", 80'(m_axis_tvalid), 80'(0));
        check_eq("mid_rst_m_word", 80'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 80'(0));
        check_eq("mid_rst_pkt_level", 80'(pkt_level), 80'(0));
        check_eq("mid_rst_drop_count", 80'(drop_count), 80'(0));
        check_eq("mid_rst_overflow", 80'(overflow), 80'(0));
        @(posedge clk);             // word 3 handshakes now
        #1;
        s_axis_tvalid = 1'b0;
        send_word({1'b0, 8'hFF, 64'hDEAD_0004}, 1'b0);
        send_word({1'b1, 8'hFF, 64'hDEAD_0005}, 1'b0);
        op0 = out_pkts;
        ready_mode = 1;
        send_pkt(4, 1'b1, 1'b0);
        wait_drain("rst_drain", 50);
        check_eq("rst_pkts_out", 80'(out_pkts - op0), 80'(1));
        check_eq("rst_level_empty", 80'(pkt_level), 80'(0));

        // ---------------- T6: drop counter saturation ----------------
        // With the DMA stalled the buffer holds 15 RAM words plus the two
        // output-stage entries: 3 x 5 words + 2 single words fill it.
        ready_mode = 0;
        wait_cycles(1);
        for (int p = 0; p < 3; p++) send_pkt(5, 1'b0, 1'b0);
        send_pkt(1, 1'b0, 1'b0);
        send_pkt(1, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) send_pkt(1, 1'b0, 1'b0);
        wait_cycles(2);
        check_eq("sat_drop_count_5", 80'(drop_count), 80'(5));
        check_eq("sat_pkt_level", 80'(pkt_level), 80'(5));
        s_axis_tdata  = 64'h5A5A;
        s_axis_tkeep  = 8'h0F;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        wait_cycles(2);
        check_eq("sat_drop_count", 80'(drop_count), 80'(16'hFFFF));
        check_eq("sat_pkt_level_hold", 80'(pkt_level), 80'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
